regfile_mp_scoreboard: RTL

//   Parametrised multi-port register file for the pipelined core. Has NUM_RD async read

---
 rtl/regfile_mp_scoreboard_pkg.sv | 24 ++
 rtl/regfile_mp_scoreboard_if.sv | 39 +++
 rtl/regfile_sb_counter.sv | 54 +++++
 rtl/regfile_mp_scoreboard.sv | 102 ++++++++++
 4 files changed

// File: rtl/regfile_mp_scoreboard_pkg.sv
// ============================================================================
// Module  : regfile_mp_scoreboard_pkg
// Brief   : Shared sizing constants and helpers for the multi-port register
//           file with pending-write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_mp_scoreboard_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;
    localparam int RF_CNT_W  = 2;

    // Bits needed to count how many of n lanes hit one register in a cycle.
    function automatic int lane_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_scoreboard_if.sv
// ============================================================================
// Module  : regfile_mp_scoreboard_if
// Brief   : Read, write-back and issue signals between the pipeline and the
//           register file / scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mp_scoreboard_if
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ready;
    logic                     flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, iss_ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, iss_ready
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb_counter.sv
// ============================================================================
// Module  : regfile_sb_counter
// Brief   : Saturating pending-write counter for one register: increments on
//           issue, decrements by the number of retiring lanes, floors at 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb_counter
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W,
    parameter int DEC_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_inc,
    input  wire logic [DEC_W-1:0] i_dec,
    input  wire logic             i_flush,
    output logic                  o_sat,
    output logic                  o_pending
);
    localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_up;
    logic [SUM_W-1:0] w_dec;
    logic [CNT_W-1:0] w_next;

    assign o_sat = (r_cnt == {CNT_W{1'b1}});

    // Retires beyond the outstanding count are absorbed rather than wrapping.
    always_comb begin
        w_up   = SUM_W'(r_cnt) + SUM_W'(i_inc && !o_sat);
        w_dec  = SUM_W'(i_dec);
        w_next = (w_dec >= w_up) ? '0 : CNT_W'(w_up - w_dec);
    end

    // Pending after this cycle ignores a same-cycle issue by design.
    assign o_pending = (SUM_W'(r_cnt) > w_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
// ============================================================================
// Module  : regfile_mp_scoreboard
// Brief   : Multi-port register file with same-cycle write bypass and a
//           per-register pending-write scoreboard for RAW hazard detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_scoreboard
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int NUM_WR = RF_NUM_WR,
    parameter int CNT_W  = RF_CNT_W
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    regfile_mp_scoreboard_if.slave  bus
);
    localparam int NREG   = 2 ** ADDR_W;
    localparam int WCNT_W = lane_cnt_w(NUM_WR);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   w_sat;
    logic [NREG-1:0]   w_pending;

    // Lanes are applied in ascending order so the highest enabled lane wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_WR; l++) begin
                if (bus.wr_en[l] && (bus.wr_addr[l*ADDR_W +: ADDR_W] != '0)) begin
                    r_regs[bus.wr_addr[l*ADDR_W +: ADDR_W]] <= bus.wr_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_sb
            logic [WCNT_W-1:0] w_wr_cnt;
            logic              w_inc;

            always_comb begin
                w_wr_cnt = '0;
                for (int l = 0; l < NUM_WR; l++) begin
                    if (bus.wr_en[l] && (bus.wr_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                        w_wr_cnt = w_wr_cnt + WCNT_W'(1);
                    end
                end
            end

            assign w_inc = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && (r != 0);

            regfile_sb_counter #(
                .CNT_W (CNT_W),
                .DEC_W (WCNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_inc     (w_inc),
                .i_dec     (w_wr_cnt),
                .i_flush   (bus.flush),
                .o_sat     (w_sat[r]),
                .o_pending (w_pending[r])
            );
        end

        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_rdata;

            assign w_addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

            always_comb begin
                w_rdata = r_regs[w_addr];
                for (int l = 0; l < NUM_WR; l++) begin
                    if (bus.wr_en[l] && (bus.wr_addr[l*ADDR_W +: ADDR_W] == w_addr)) begin
                        w_rdata = bus.wr_data[l*DATA_W +: DATA_W];
                    end
                end
                // Bypass must not leak through while reset is held.
                if ((w_addr == '0) || !rst_n) begin
                    w_rdata = '0;
                end
            end

            assign bus.rd_data[p*DATA_W +: DATA_W] = w_rdata;
            assign bus.rd_busy[p]                  = w_pending[w_addr];
        end
    endgenerate

    assign bus.iss_ready = ~w_sat[bus.iss_addr];

endmodule

`default_nettype wire
